// File: rtl/posicoes_pkg.sv
// Shared types and constants for the XY position reader.
// Holds the FSM state type, the border mask and the payload field geometry.
package posicoes_pkg;

    localparam int unsigned Y_W       = 10;
    localparam int unsigned CAMPO_LSB = 2;
    localparam int unsigned CAMPO_W   = 6;
    localparam int unsigned CONT_W    = 4;

    localparam logic [Y_W-1:0] BORDA_MASK = 10'b11_0000_0011;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONFIRMA = 2'd1,
        ENTREGA  = 2'd2
    } estado_leitor_t;

endpackage

// File: rtl/posicoes_xy_leitor_contador.sv
// contador_confirmacao: debounce counter for the position payload.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   amostra           a clean strobed sample is being accepted this edge
//   carrega           reader is idle: the sample starts a fresh run
//   zera              force the run length to zero (border error, repeat, transfer)
//   payload           6-bit payload of the current sample
//   candidato_prox_c  candidate value after this edge (combinational)
//   confirmado_c      this edge completes CICLOS_CONFIRMA matching samples (combinational)
module contador_confirmacao
    import posicoes_pkg::*;
#(
    parameter int unsigned CICLOS_CONFIRMA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               amostra,
    input  logic               carrega,
    input  logic               zera,
    input  logic [CAMPO_W-1:0] payload,
    output logic [CAMPO_W-1:0] candidato_prox_c,
    output logic               confirmado_c
);

    localparam logic [CONT_W-1:0] LIMITE = CONT_W'(CICLOS_CONFIRMA);

    logic [CAMPO_W-1:0] candidato_q, candidato_d;
    logic [CONT_W-1:0]  cont_q, cont_d, cont_prox;

    // Next run length for an accepted sample; confirmation ignores zera so the
    // top can decide delivery vs. repeat-discard without a combinational loop.
    always_comb begin
        cont_prox = CONT_W'(1);
        if (!carrega && (payload == candidato_q)) begin
            cont_prox = (cont_q >= LIMITE) ? LIMITE : CONT_W'(cont_q + CONT_W'(1));
        end
        candidato_d = amostra ? payload : candidato_q;
        cont_d      = cont_q;
        if (amostra) begin
            cont_d = cont_prox;
        end
        if (zera) begin
            cont_d = '0;
        end
        confirmado_c = amostra && (cont_prox == LIMITE);
    end

    assign candidato_prox_c = candidato_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidato_q <= '0;
            cont_q      <= '0;
        end else begin
            candidato_q <= candidato_d;
            cont_q      <= cont_d;
        end
    end

endmodule

// File: rtl/posicoes_xy_leitor.sv
// posicoes_xy_leitor: receives the 10-bit XY position vector, checks the
// border bits, debounces the payload and delivers each new stable value
// over a valid/ready handshake.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   y_in         position vector, payload on [7:2], border on [9:8] and [1:0]
//   amostra_en   sample strobe
//   dado         delivered payload (A = dado[0] .. F = dado[5])
//   valido       dado holds an undelivered value
//   pronto       consumer accepts dado
//   erro_borda   one-cycle pulse after a strobed sample with a border bit set
module posicoes_xy_leitor
    import posicoes_pkg::*;
#(
    parameter int unsigned CICLOS_CONFIRMA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [Y_W-1:0]     y_in,
    input  logic               amostra_en,
    output logic [CAMPO_W-1:0] dado,
    output logic               valido,
    input  logic               pronto,
    output logic               erro_borda
);

    estado_leitor_t     estado_q, estado_d;
    logic [CAMPO_W-1:0] dado_q, dado_d;
    logic [CAMPO_W-1:0] ultimo_q, ultimo_d;
    logic               valido_q, valido_d;
    logic               erro_borda_q, erro_borda_d;
    logic               primeiro_q, primeiro_d;

    logic               borda_c, aceita_c, carrega_c, zera_c, confirmado_c;
    logic [CAMPO_W-1:0] candidato_prox_c;

    // Strobes are only looked at while not holding a value for the consumer.
    assign borda_c   = (y_in & BORDA_MASK) != '0;
    assign aceita_c  = amostra_en && !borda_c && (estado_q != ENTREGA);
    assign carrega_c = (estado_q == OCIOSO);

    contador_confirmacao #(
        .CICLOS_CONFIRMA (CICLOS_CONFIRMA)
    ) u_contador (
        .clk              (clk),
        .rst_n            (rst_n),
        .amostra          (aceita_c),
        .carrega          (carrega_c),
        .zera             (zera_c),
        .payload          (y_in[CAMPO_LSB +: CAMPO_W]),
        .candidato_prox_c (candidato_prox_c),
        .confirmado_c     (confirmado_c)
    );

    // Next-state and output logic.
    always_comb begin
        estado_d     = estado_q;
        dado_d       = dado_q;
        valido_d     = valido_q;
        ultimo_d     = ultimo_q;
        primeiro_d   = primeiro_q;
        erro_borda_d = 1'b0;
        zera_c       = 1'b0;
        case (estado_q)
            OCIOSO, CONFIRMA: begin
                if (amostra_en) begin
                    if (borda_c) begin
                        erro_borda_d = 1'b1;
                        zera_c       = 1'b1;
                        estado_d     = OCIOSO;
                    end else begin
                        estado_d = CONFIRMA;
                        if (confirmado_c) begin
                            if (primeiro_q || (candidato_prox_c != ultimo_q)) begin
                                dado_d   = candidato_prox_c;
                                valido_d = 1'b1;
                                estado_d = ENTREGA;
                            end else begin
                                // Same value as the last delivery: drop it silently.
                                zera_c   = 1'b1;
                                estado_d = OCIOSO;
                            end
                        end
                    end
                end
            end
            ENTREGA: begin
                if (valido_q && pronto) begin
                    ultimo_d   = dado_q;
                    primeiro_d = 1'b0;
                    valido_d   = 1'b0;
                    zera_c     = 1'b1;
                    estado_d   = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
                valido_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            dado_q       <= '0;
            valido_q     <= 1'b0;
            erro_borda_q <= 1'b0;
            ultimo_q     <= '0;
            primeiro_q   <= 1'b1;
        end else begin
            estado_q     <= estado_d;
            dado_q       <= dado_d;
            valido_q     <= valido_d;
            erro_borda_q <= erro_borda_d;
            ultimo_q     <= ultimo_d;
            primeiro_q   <= primeiro_d;
        end
    end

    assign dado       = dado_q;
    assign valido     = valido_q;
    assign erro_borda = erro_borda_q;

endmodule

// File: tb/tb_posicoes_xy_leitor.sv
// Self-checking bench for posicoes_xy_leitor (CICLOS_CONFIRMA = 4).
// A run-length model predicts dado/valido/erro_borda every cycle; directed
// scenarios pin the model with literal expectations, then random traffic runs.
module tb_posicoes_xy_leitor;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] y_in;
    logic       amostra_en;
    logic [5:0] dado;
    logic       valido;
    logic       pronto;
    logic       erro_borda;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_pend  = 0;
    int m_dado  = 0;
    int m_err   = 0;
    int m_len   = 0;
    int m_val   = 0;
    int m_ult   = 0;
    int m_first = 1;

    int n_ent   = 0;
    int ult_ent = 0;
    int n_err   = 0;

    posicoes_xy_leitor #(.CICLOS_CONFIRMA(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y_in       (y_in),
        .amostra_en (amostra_en),
        .dado       (dado),
        .valido     (valido),
        .pronto     (pronto),
        .erro_borda (erro_borda)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Model: a run of identical clean samples of length N delivers, unless it
    // repeats the last delivered value; a held value ignores all strobes.
    always @(posedge clk) begin
        int p;
        if (rst_n && valido && pronto) begin
            n_ent++;
            ult_ent = int'(dado);
        end
        if (erro_borda) n_err++;
        if (!rst_n) begin
            m_pend = 0; m_dado = 0; m_err = 0; m_len = 0;
            m_val = 0; m_ult = 0; m_first = 1;
        end else if (m_pend != 0) begin
            m_err = 0;
            if (pronto) begin
                m_ult   = m_dado;
                m_first = 0;
                m_pend  = 0;
                m_len   = 0;
            end
        end else begin
            m_err = 0;
            if (amostra_en) begin
                if ((y_in & 10'h303) != 10'h000) begin
                    m_err = 1;
                    m_len = 0;
                end else begin
                    p = int'(y_in) / 4;
                    if (m_len > 0 && p == m_val) begin
                        m_len++;
                    end else begin
                        m_val = p;
                        m_len = 1;
                    end
                    if (m_len == N) begin
                        if (m_first != 0 || p != m_ult) begin
                            m_pend = 1;
                            m_dado = p;
                        end else begin
                            m_len = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_dado", int'(dado), m_dado);
        chk("model_valido", int'(valido), m_pend);
        chk("model_erro_borda", int'(erro_borda), m_err);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] v);
        y_in       = v;
        amostra_en = 1'b1;
        tick();
        amostra_en = 1'b0;
    endtask

    task automatic idle(input int n);
        amostra_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valido_imediato", int'(valido), 0);
        chk("rst_dado_imediato", int'(dado), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int e0, r0, sel;
        logic [9:0] v;
        rst_n = 1'b0; y_in = '0; amostra_en = 1'b0; pronto = 1'b0;
        @(negedge clk); #1;
        tick();
        chk("reset_valido", int'(valido), 0);
        chk("reset_dado", int'(dado), 0);
        chk("reset_erro", int'(erro_borda), 0);
        rst_n = 1'b1;

        // Basic delivery with pronto held high.
        pronto = 1'b1; e0 = n_ent; r0 = n_err;
        repeat (4) strobe(10'b00_1010_1100);
        chk("s1_valido", int'(valido), 1);
        chk("s1_dado", int'(dado), 6'b101011);
        tick();
        chk("s1_valido_baixo", int'(valido), 0);
        idle(2);
        chk("s1_entregas", n_ent - e0, 1);
        chk("s1_ultimo", ult_ent, 43);
        chk("s1_erros", n_err - r0, 0);

        // Count restarts on a payload change.
        do_reset(); pronto = 1'b1; e0 = n_ent;
        strobe(10'h0AC); strobe(10'h0AC);
        repeat (5) strobe(10'h0B0);
        idle(3);
        chk("s2_entregas", n_ent - e0, 1);
        chk("s2_ultimo", ult_ent, 44);

        // Repeat of the last delivered value is suppressed.
        do_reset(); pronto = 1'b1; e0 = n_ent;
        repeat (4) strobe(10'h0AC);
        idle(2);
        repeat (4) strobe(10'h0AC);
        idle(3);
        chk("s3_sem_repeticao", n_ent - e0, 1);
        repeat (4) strobe(10'h004);
        idle(2);
        chk("s3_entregas", n_ent - e0, 2);
        chk("s3_ultimo", ult_ent, 1);

        // Border error in CONFIRMA clears the count.
        do_reset(); pronto = 1'b1; e0 = n_ent; r0 = n_err;
        strobe(10'h0AC); strobe(10'h0AC);
        strobe(10'h201);
        chk("s4_erro_pulso", int'(erro_borda), 1);
        strobe(10'h0AC);
        chk("s4_erro_um_ciclo", int'(erro_borda), 0);
        strobe(10'h0AC); strobe(10'h0AC);
        idle(3);
        chk("s4_sem_entrega", n_ent - e0, 0);
        chk("s4_erros", n_err - r0, 1);
        strobe(10'h0AC);
        idle(2);
        chk("s4_entrega_apos", n_ent - e0, 1);

        // Backpressure: value held, strobes ignored.
        do_reset(); pronto = 1'b0; e0 = n_ent; r0 = n_err;
        repeat (4) strobe(10'h0AC);
        for (int i = 0; i < 10; i++) begin
            y_in = 10'($urandom);
            amostra_en = 1'b1;
            tick();
            chk("s5_valido_mantido", int'(valido), 1);
            chk("s5_dado_mantido", int'(dado), 43);
        end
        amostra_en = 1'b0; pronto = 1'b1;
        tick();
        chk("s5_valido_apos", int'(valido), 0);
        chk("s5_entregas", n_ent - e0, 1);
        chk("s5_erros", n_err - r0, 0);

        // Reset during ENTREGA and mid-CONFIRMA.
        do_reset(); pronto = 1'b1;
        repeat (4) strobe(10'h0AC);
        idle(2);
        pronto = 1'b0;
        repeat (4) strobe(10'h004);
        chk("s6_valido_entrega", int'(valido), 1);
        e0 = n_ent;
        do_reset();
        pronto = 1'b1;
        strobe(10'h0AC); strobe(10'h0AC);
        do_reset();
        repeat (3) strobe(10'h0AC);
        idle(2);
        chk("s6_sem_entrega", n_ent - e0, 0);
        strobe(10'h0AC);
        idle(2);
        chk("s6_entrega", n_ent - e0, 1);
        chk("s6_ultimo", ult_ent, 43);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: v = 10'h0AC;
                3, 4:    v = 10'h0B0;
                5:       v = 10'h004;
                6, 7:    v = {2'b00, 6'($urandom), 2'b00};
                8:       v = 10'($urandom);
                default: v = 10'h201;
            endcase
            y_in       = v;
            amostra_en = ($urandom_range(0, 9) < 7);
            pronto     = 1'($urandom_range(0, 1));
            rst_n      = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
